// File: rtl/io_bus_arbiter.sv
// Two-master access controller in front of the memory-mapped I/O block.
// Master 0 has fixed priority; a wait counter guarantees master 1 a grant after MAX_WAIT losses.
module io_bus_arbiter #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_data_in,
    output logic              io_write_enable,
    input  logic [DATA_W-1:0] io_data_out
);
    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StAck} state_e;

    // Addresses above this one are not writable; the I/O block blanks its outputs on them.
    localparam logic [ADDR_W-1:0] LastWritable = ADDR_W'(4);
    localparam logic [3:0]        WaitMax      = 4'(MAX_WAIT);

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [DATA_W-1:0] io_data_q, io_data_d;
    logic              io_we_q, io_we_d;
    logic              m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic              m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic              grant_m1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              reject;

    assign grant_m1  = m1_req && ((wait_q == WaitMax) || !m0_req);
    assign sel_we    = grant_m1 ? m1_we    : m0_we;
    assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
    assign reject    = we_q && (addr_q > LastWritable);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        io_addr_d  = io_addr_q;
        io_data_d  = io_data_q;
        io_we_d    = 1'b0;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (!m1_req) begin
                    wait_d = '0;
                end
                if (m0_req || m1_req) begin
                    win_d     = grant_m1;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    io_addr_d = sel_addr;
                    io_data_d = sel_wdata;
                    io_we_d   = sel_we && (sel_addr <= LastWritable);
                    if (grant_m1) begin
                        wait_d = '0;
                    end else if (m1_req && (wait_q != WaitMax)) begin
                        wait_d = wait_q + 4'd1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                if (win_q) begin
                    m1_ack_d = 1'b1;
                    m1_err_d = reject;
                    if (!we_q) begin
                        m1_rdata_d = io_data_out;
                    end
                end else begin
                    m0_ack_d = 1'b1;
                    m0_err_d = reject;
                    if (!we_q) begin
                        m0_rdata_d = io_data_out;
                    end
                end
                state_d = StAck;
            end
            StAck: begin
                io_addr_d = '0;
                io_data_d = '0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wait_q     <= '0;
            io_addr_q  <= '0;
            io_data_q  <= '0;
            io_we_q    <= 1'b0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            io_addr_q  <= io_addr_d;
            io_data_q  <= io_data_d;
            io_we_q    <= io_we_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_ack          = m0_ack_q;
    assign m0_err          = m0_err_q;
    assign m0_rdata        = m0_rdata_q;
    assign m1_ack          = m1_ack_q;
    assign m1_err          = m1_err_q;
    assign m1_rdata        = m1_rdata_q;
    assign io_addr         = io_addr_q;
    assign io_data_in      = io_data_q;
    assign io_write_enable = io_we_q;
endmodule
